// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: TDM demux bus; master drives din/din_valid/frame_start, slave drives ch0..ch3/out_valid/frame_err/sel/busy
interface tdm_demux4_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_start;
  logic [WIDTH-1:0] ch0;
  logic [WIDTH-1:0] ch1;
  logic [WIDTH-1:0] ch2;
  logic [WIDTH-1:0] ch3;
  logic             out_valid;
  logic             frame_err;
  logic [1:0]       sel;
  logic             busy;
  modport master (
    output din, din_valid, frame_start,
    input  ch0, ch1, ch2, ch3, out_valid, frame_err, sel, busy
  );
  modport slave (
    input  din, din_valid, frame_start,
    output ch0, ch1, ch2, ch3, out_valid, frame_err, sel, busy
  );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM demux; ports clk, rst_n (async low), bus.slave (din/din_valid/frame_start in; ch0..3/out_valid/frame_err/sel/busy out)
module tdm_demux4 #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst_n,
  tdm_demux4_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CW-1:0]    idle_q, idle_d;
  logic [WIDTH-1:0] shadow_q [0:2];
  logic [WIDTH-1:0] shadow_d [0:2];
  logic [WIDTH-1:0] ch_q [0:3];
  logic [WIDTH-1:0] ch_d [0:3];
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idle_d      = idle_q;
    shadow_d    = shadow_q;
    ch_d        = ch_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.din_valid && bus.frame_start) begin
        shadow_d[0] = bus.din;
        sel_d       = 2'd1;
        idle_d      = '0;
        state_d     = COLLECT;
      end
    end else if (bus.din_valid && bus.frame_start) begin
      // early restart: drop the partial frame, this word becomes slot 0
      frame_err_d = 1'b1;
      shadow_d[0] = bus.din;
      sel_d       = 2'd1;
      idle_d      = '0;
    end else if (bus.din_valid && sel_q == 2'd3) begin
      // slot 3 goes straight to the output, never through a shadow
      ch_d[0]     = shadow_q[0];
      ch_d[1]     = shadow_q[1];
      ch_d[2]     = shadow_q[2];
      ch_d[3]     = bus.din;
      out_valid_d = 1'b1;
      sel_d       = 2'd0;
      idle_d      = '0;
      state_d     = IDLE;
    end else if (bus.din_valid) begin
      shadow_d[sel_q] = bus.din;
      sel_d           = sel_q + 2'd1;
      idle_d          = '0;
    end else if (idle_q == TLAST) begin
      frame_err_d = 1'b1;
      sel_d       = 2'd0;
      idle_d      = '0;
      state_d     = IDLE;
    end else begin
      idle_d = (idle_q == CMAX) ? idle_q : idle_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      idle_q      <= '0;
      shadow_q    <= '{default: '0};
      ch_q        <= '{default: '0};
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idle_q      <= idle_d;
      shadow_q    <= shadow_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign bus.ch0       = ch_q[0];
  assign bus.ch1       = ch_q[1];
  assign bus.ch2       = ch_q[2];
  assign bus.ch3       = ch_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == COLLECT);
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized + directed scoreboard bench for tdm_demux4
module tb_tdm_demux4;
  localparam int W  = 8;
  localparam int TO = 4;
  typedef struct packed {
    int          cyc;
    logic [31:0] ch;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tdm_demux4_if #(.WIDTH(W)) bus();
  tdm_demux4 #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  ev_t        fq[$];
  int         eq[$];
  logic [7:0] cur[$];
  bit         active = 1'b0;
  int         gap = 0;
  int         chk = 0;
  int         errs = 0;
  logic [31:0] held = '0;
  ev_t        e_m;
  int         c_m;
  task automatic step(input bit v, input bit s, input logic [7:0] d);
    int es;
    bus.din_valid   = v;
    bus.frame_start = s;
    bus.din         = d;
    @(posedge clk);
    #1;
    if (v && s) begin
      if (active) eq.push_back(cyc);
      cur = {d};
      active = 1'b1;
      gap = 0;
    end else if (v && active) begin
      cur.push_back(d);
      gap = 0;
      if (cur.size() == 4) begin
        fq.push_back('{cyc, {cur[0], cur[1], cur[2], cur[3]}});
        cur = {};
        active = 1'b0;
      end
    end else if (!v && active) begin
      gap++;
      if (gap == TO) begin
        eq.push_back(cyc);
        cur = {};
        active = 1'b0;
      end
    end
    es = active ? cur.size() : 0;
    chk++;
    if (bus.sel !== 2'(es) || bus.busy !== active) begin
      errs++;
      $display("FAIL sel_busy cyc=%0d got sel=%0d busy=%0b want sel=%0d busy=%0b", cyc, bus.sel, bus.busy, es, active);
    end
  endtask
  task automatic frame(input logic [31:0] w, input int g);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) repeat (g) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      step(1'b1, i == 0, w[31-8*i -: 8]);
    end
  endtask
  task automatic do_reset();
    bus.din_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    cur = {};
    active = 1'b0;
    gap = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      chk++;
      if ({bus.ch0, bus.ch1, bus.ch2, bus.ch3, bus.out_valid, bus.frame_err, bus.sel, bus.busy} !== '0) begin
        errs++;
        $display("FAIL reset_outputs got ch=%h ov=%b fe=%b sel=%0d busy=%b want all zero",
                 {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, bus.out_valid, bus.frame_err, bus.sel, bus.busy);
      end
      held = '0;
    end else begin
      chk++;
      if (bus.out_valid) begin
        if (fq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_out_valid cyc=%0d got ch=%h want no pulse", cyc, {bus.ch0, bus.ch1, bus.ch2, bus.ch3});
          held = {bus.ch0, bus.ch1, bus.ch2, bus.ch3};
        end else begin
          e_m = fq.pop_front();
          if (e_m.cyc != cyc || {bus.ch0, bus.ch1, bus.ch2, bus.ch3} !== e_m.ch) begin
            errs++;
            $display("FAIL frame_out got cyc=%0d ch=%h want cyc=%0d ch=%h", cyc, {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, e_m.cyc, e_m.ch);
          end
          held = e_m.ch;
        end
      end else if ({bus.ch0, bus.ch1, bus.ch2, bus.ch3} !== held) begin
        errs++;
        $display("FAIL ch_hold cyc=%0d got ch=%h want ch=%h", cyc, {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, held);
      end
      if (bus.frame_err) begin
        chk++;
        if (eq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_frame_err cyc=%0d got pulse want none", cyc);
        end else begin
          c_m = eq.pop_front();
          if (c_m != cyc) begin
            errs++;
            $display("FAIL frame_err_time got cyc=%0d want cyc=%0d", cyc, c_m);
          end
        end
      end
    end
  end
  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.frame_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    frame(32'h11223344, 0);
    step(1'b0, 1'b0, 8'h00);
    frame(32'h11223344, 2);
    step(1'b1, 1'b1, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    frame(32'hB1B2B3B4, 0);
    step(1'b1, 1'b1, 8'h55);
    step(1'b1, 1'b0, 8'h66);
    repeat (TO) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 8'h00);
    frame(32'h01020304, 0);
    frame(32'h05060708, 0);
    step(1'b1, 1'b1, 8'hD1);
    step(1'b1, 1'b0, 8'hD2);
    step(1'b1, 1'b0, 8'hD3);
    do_reset();
    frame(32'hC1C2C3C4, 0);
    step(1'b1, 1'b1, 8'hE1);
    repeat (TO - 1) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'hE2);
    repeat (TO - 1) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'hE3);
    step(1'b1, 1'b0, 8'hE4);
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 59) repeat (TO + 1) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (i % 7 == 0) frame($urandom, $urandom_range(0, TO - 1));
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 8'($urandom));
    end
    repeat (TO + 2) step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    chk++;
    if (fq.size() != 0 || eq.size() != 0) begin
      errs++;
      $display("FAIL pending_events got frames=%0d errs=%0d left want 0", fq.size(), eq.size());
    end
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
